// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common data bus arbiter: slot count and the registered slot record.
package cdb_arbiter_pkg;

   localparam int CDB_SLOTS = 2;

   typedef struct packed {
      logic        valid;
      logic [31:0] result;
      logic [5:0]  arn;
      logic [5:0]  rrn;
      logic        tag;
   } cdb_slot_t;

endpackage

// File: rtl/rr_pick.sv
// Circular find-first-set: returns the first set bit of mask at or after start, wrapping once.
module rr_pick #(
   parameter int WIDTH = 4,
   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0] mask,
   input  logic [IDX_W-1:0] start,
   output logic             found,
   output logic [IDX_W-1:0] index
);

   always_comb begin
      int pos;
      found = 1'b0;
      index = '0;
      pos   = 0;
      for (int k = 0; k < WIDTH; k++) begin
         pos = (int'(start) + k) % WIDTH;
         if (!found && mask[pos]) begin
            found = 1'b1;
            index = IDX_W'(pos);
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter granting up to two execution-unit results per cycle onto the two CDB slots.
// Optional saturating performance counters are enabled by defining CDB_ARBITER_PERF_EN.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 delete_tag,
   input  logic                 clear_tag,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ*32-1:0] req_result,
   input  logic [NUM_REQ*6-1:0] req_arn,
   input  logic [NUM_REQ*6-1:0] req_rrn,
   input  logic [NUM_REQ-1:0]   req_tag,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [1:0]           cdb_valid,
   output logic [63:0]          cdb_result,
   output logic [11:0]          cdb_arn,
   output logic [11:0]          cdb_rrn,
   output logic [1:0]           cdb_tag
`ifdef CDB_ARBITER_PERF_EN
   ,
   output logic [NUM_REQ*32-1:0] perf_grants,
   output logic [31:0]          perf_stall
`endif
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [IDX_W-1:0]   ptr_reg, ptr_next;
   logic [NUM_REQ-1:0] elig, flush, mask1, granted;
   logic               found0, found1;
   logic [IDX_W-1:0]   idx0, idx1;
   logic [31:0]        result_arr [NUM_REQ];
   logic [5:0]         arn_arr    [NUM_REQ];
   logic [5:0]         rrn_arr    [NUM_REQ];
   cdb_slot_t          slot_reg   [CDB_SLOTS];
   cdb_slot_t          slot_next  [CDB_SLOTS];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign result_arr[gi] = req_result[gi*32 +: 32];
         assign arn_arr[gi]    = req_arn[gi*6 +: 6];
         assign rrn_arr[gi]    = req_rrn[gi*6 +: 6];
      end
   endgenerate

   // Flushed requests are acknowledged but never compete for a slot.
   assign flush = req_valid & req_tag & {NUM_REQ{delete_tag}};
   assign elig  = req_valid & ~flush;

   rr_pick #(.WIDTH(NUM_REQ)) u_pick0 (
      .mask  (elig),
      .start (ptr_reg),
      .found (found0),
      .index (idx0)
   );

   assign mask1 = found0 ? (elig & ~(NUM_REQ'(1) << idx0)) : '0;

   rr_pick #(.WIDTH(NUM_REQ)) u_pick1 (
      .mask  (mask1),
      .start (ptr_reg),
      .found (found1),
      .index (idx1)
   );

   always_comb begin
      granted = '0;
      if (found0) granted = granted | (NUM_REQ'(1) << idx0);
      if (found1) granted = granted | (NUM_REQ'(1) << idx1);
   end

   assign req_ready = reset ? (granted | flush) : '0;

   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
      return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
   endfunction

   always_comb begin
      slot_next[0] = '0;
      slot_next[1] = '0;
      ptr_next     = ptr_reg;
      if (found0) begin
         slot_next[0] = '{valid: 1'b1, result: result_arr[idx0], arn: arn_arr[idx0],
                          rrn: rrn_arr[idx0], tag: req_tag[idx0] & ~clear_tag};
         ptr_next     = wrap_inc(idx0);
      end
      if (found1) begin
         slot_next[1] = '{valid: 1'b1, result: result_arr[idx1], arn: arn_arr[idx1],
                          rrn: rrn_arr[idx1], tag: req_tag[idx1] & ~clear_tag};
         ptr_next     = wrap_inc(idx1);
      end
   end

   // Slots reload every cycle, so a tagged slot seen during a flush is gone the cycle after.
   always_ff @(posedge clock) begin
      if (!reset) begin
         ptr_reg <= '0;
         for (int s = 0; s < CDB_SLOTS; s++) slot_reg[s] <= '0;
      end else begin
         ptr_reg <= ptr_next;
         for (int s = 0; s < CDB_SLOTS; s++) slot_reg[s] <= slot_next[s];
      end
   end

   generate
      for (gi = 0; gi < CDB_SLOTS; gi++) begin : g_slot_out
         assign cdb_valid[gi]          = slot_reg[gi].valid;
         assign cdb_result[gi*32 +: 32] = slot_reg[gi].result;
         assign cdb_arn[gi*6 +: 6]     = slot_reg[gi].arn;
         assign cdb_rrn[gi*6 +: 6]     = slot_reg[gi].rrn;
         assign cdb_tag[gi]            = slot_reg[gi].tag;
      end
   endgenerate

`ifdef CDB_ARBITER_PERF_EN
   logic [31:0] grant_cnt_reg [NUM_REQ];
   logic [31:0] stall_cnt_reg;
   logic        stall_next;

   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_perf
         always_ff @(posedge clock) begin
            if (!reset)
               grant_cnt_reg[gi] <= '0;
            else if (granted[gi] && grant_cnt_reg[gi] != '1)
               grant_cnt_reg[gi] <= grant_cnt_reg[gi] + 32'd1;
         end
         assign perf_grants[gi*32 +: 32] = grant_cnt_reg[gi];
      end
   endgenerate

   always_comb begin
      int cnt;
      cnt = 0;
      for (int k = 0; k < NUM_REQ; k++) cnt = cnt + int'(elig[k]);
      stall_next = (cnt > 2);
   end

   always_ff @(posedge clock) begin
      if (!reset)
         stall_cnt_reg <= '0;
      else if (stall_next && stall_cnt_reg != '1)
         stall_cnt_reg <= stall_cnt_reg + 32'd1;
   end

   assign perf_stall = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed cases then random traffic against a queue-based model.
module tb_cdb_arbiter;

   localparam int N = 4;

   logic             clock = 1'b0;
   logic             reset;
   logic             delete_tag, clear_tag;
   logic [N-1:0]     req_valid, req_tag, req_ready;
   logic [N*32-1:0]  req_result;
   logic [N*6-1:0]   req_arn, req_rrn;
   logic [1:0]       cdb_valid, cdb_tag;
   logic [63:0]      cdb_result;
   logic [11:0]      cdb_arn, cdb_rrn;
`ifdef CDB_ARBITER_PERF_EN
   logic [N*32-1:0]  perf_grants;
   logic [31:0]      perf_stall;
`endif

   int total = 0;
   int bad   = 0;
   int ptr_m = 0;

   cdb_arbiter #(.NUM_REQ(N)) dut (
      .clock      (clock),
      .reset      (reset),
      .delete_tag (delete_tag),
      .clear_tag  (clear_tag),
      .req_valid  (req_valid),
      .req_result (req_result),
      .req_arn    (req_arn),
      .req_rrn    (req_rrn),
      .req_tag    (req_tag),
      .req_ready  (req_ready),
      .cdb_valid  (cdb_valid),
      .cdb_result (cdb_result),
      .cdb_arn    (cdb_arn),
      .cdb_rrn    (cdb_rrn),
      .cdb_tag    (cdb_tag)
`ifdef CDB_ARBITER_PERF_EN
      ,
      .perf_grants(perf_grants),
      .perf_stall (perf_stall)
`endif
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   function automatic logic [63:0] obs_slot(input int s);
      return {18'd0, cdb_valid[s], cdb_tag[s], cdb_arn[s*6 +: 6], cdb_rrn[s*6 +: 6],
              cdb_result[s*32 +: 32]};
   endfunction

   task automatic set_payload(input int i, input logic [31:0] r, input logic [5:0] a,
                              input logic [5:0] rr);
      req_result[i*32 +: 32] = r;
      req_arn[i*6 +: 6]      = a;
      req_rrn[i*6 +: 6]      = rr;
   endtask

   // One transaction: entered just after a rising edge, leaves just after the next one.
   task automatic step(input string name, input logic [N-1:0] v, input logic [N-1:0] t,
                       input logic del, input logic clr);
      int            w[$];
      logic [N-1:0]  rdy;
      logic [63:0]   exp;
      req_valid  = v;
      req_tag    = t;
      delete_tag = del;
      clear_tag  = clr;
      #2;
      w   = {};
      rdy = '0;
      for (int k = 0; k < N; k++) begin
         int i;
         i = (ptr_m + k) % N;
         if (v[i] && del && t[i]) rdy[i] = 1'b1;
         else if (v[i] && w.size() < 2) begin
            w.push_back(i);
            rdy[i] = 1'b1;
         end
      end
      chk({name, "/ready"}, 64'(req_ready), 64'(rdy));
      @(posedge clock);
      #1;
      for (int s = 0; s < 2; s++) begin
         exp = '0;
         if (s < w.size())
            exp = {18'd0, 1'b1, (clr ? 1'b0 : t[w[s]]), req_arn[w[s]*6 +: 6],
                   req_rrn[w[s]*6 +: 6], req_result[w[s]*32 +: 32]};
         chk($sformatf("%s/slot%0d", name, s), obs_slot(s), exp);
      end
      $display("step %s valid=%b tag=%b del=%b clr=%b granted=%0d cdb_valid=%b",
               name, v, t, del, clr, w.size(), cdb_valid);
      if (w.size() > 0) ptr_m = (w[w.size()-1] + 1) % N;
   endtask

   initial begin
      reset      = 1'b0;
      delete_tag = 1'b0;
      clear_tag  = 1'b0;
      req_valid  = '1;
      req_tag    = '0;
      req_result = '0;
      req_arn    = '0;
      req_rrn    = '0;
      for (int i = 0; i < N; i++) set_payload(i, 32'h1000_0000 + i, 6'(i + 10), 6'(i + 20));

      // Reset held three cycles with every requester valid.
      for (int c = 0; c < 3; c++) begin
         @(posedge clock);
         #1;
         chk($sformatf("reset%0d/ready", c), 64'(req_ready), 64'd0);
         chk($sformatf("reset%0d/slot0", c), obs_slot(0), 64'd0);
         chk($sformatf("reset%0d/slot1", c), obs_slot(1), 64'd0);
      end
      reset = 1'b1;
      ptr_m = 0;

      // Full contention from ptr 0: pairs {0,1},{2,3},{0,1},{2,3}.
      for (int c = 0; c < 4; c++) step($sformatf("full%0d", c), 4'b1111, 4'b0000, 1'b0, 1'b0);

      set_payload(2, 32'hDEADBEEF, 6'd7, 6'd5);
      step("single", 4'b0100, 4'b0000, 1'b0, 1'b0);
      chk("single/ptr_model", 64'(ptr_m), 64'd3);
      step("wrap", 4'b1001, 4'b0000, 1'b0, 1'b0);
      chk("wrap/slot0_is_req3", 64'(cdb_result[31:0]), 64'h1000_0003);

      // Put a speculative result on the bus, then flush it.
      step("pre_flush", 4'b0001, 4'b0001, 1'b0, 1'b0);
      step("flush", 4'b0011, 4'b0001, 1'b1, 1'b0);

      step("tagged", 4'b0100, 4'b0100, 1'b0, 1'b0);
      step("clear", 4'b0100, 4'b0100, 1'b0, 1'b1);
      step("del_and_clear", 4'b0110, 4'b0110, 1'b1, 1'b1);
      step("idle", 4'b0000, 4'b0000, 1'b0, 1'b0);

      for (int n = 0; n < 300; n++) begin
         for (int i = 0; i < N; i++) set_payload(i, $urandom, 6'($urandom), 6'($urandom));
         step($sformatf("rand%0d", n), N'($urandom), N'($urandom & $urandom),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      end

      // Reset in the middle of traffic drops the pending grant.
      req_valid = 4'b1111;
      reset     = 1'b0;
      #2;
      chk("midreset/ready", 64'(req_ready), 64'd0);
      @(posedge clock);
      #1;
      chk("midreset/slot0", obs_slot(0), 64'd0);
      chk("midreset/slot1", obs_slot(1), 64'd0);
      reset = 1'b1;
      ptr_m = 0;
      step("after_reset", 4'b1111, 4'b0000, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
